// File: rtl/stack_pkg.sv
// stack_pkg: shared types and constants for the stack_engine slice.
// Optional feature macro used by the slice: STACK_ENGINE_UNDERFLOW_ERR_EN.
package stack_pkg;

    typedef enum logic {
        PUSH = 1'b0,
        POP  = 1'b1
    } stack_op_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } stack_rsp_st_t;

    localparam int STACK_RSP_DEPTH = 2;

endpackage

// File: rtl/stack_engine_if.sv
// stack_engine_if: command and response channels of the stack engine.
// master = requesting stage / data sink, slave = stack_engine.
// Optional feature macro used by the slice: STACK_ENGINE_UNDERFLOW_ERR_EN.
interface stack_engine_if #(
    parameter int W = 32
);
    logic         i_cmd_vld;
    logic         i_cmd_op;
    logic [W-1:0] i_cmd_dat;
    logic         o_cmd_rdy;
    logic         o_rsp_vld;
    logic [W-1:0] o_rsp_dat;
    logic         o_rsp_err;
    logic         i_rsp_rdy;

    modport master (
        output i_cmd_vld, i_cmd_op, i_cmd_dat, i_rsp_rdy,
        input  o_cmd_rdy, o_rsp_vld, o_rsp_dat, o_rsp_err
    );

    modport slave (
        input  i_cmd_vld, i_cmd_op, i_cmd_dat, i_rsp_rdy,
        output o_cmd_rdy, o_rsp_vld, o_rsp_dat, o_rsp_err
    );
endinterface

// File: rtl/stack_rsp_buf.sv
// stack_rsp_buf: two-entry response buffer holding {err, dat}.
// The head slot doubles as the register stage of the array's synchronous
// read, so a pop's data is presented the cycle after it is accepted.
// Optional feature macro used by the slice: STACK_ENGINE_UNDERFLOW_ERR_EN.
module stack_rsp_buf
    import stack_pkg::*;
#(
    parameter int W = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enq_vld_i,
    input  logic          enq_err_i,
    input  logic [W-1:0]  enq_dat_i,
    input  logic          deq_rdy_i,
    output logic          rsp_err_o,
    output logic [W-1:0]  rsp_dat_o,
    output stack_rsp_st_t state_o
);

    stack_rsp_st_t state_q;
    logic [W-1:0]  headDat_q;
    logic          headErr_q;
    logic [W-1:0]  tailDat_q;
    logic          tailErr_q;
    logic          deq;

    assign deq       = (state_q != EMPTY) && deq_rdy_i;
    assign rsp_dat_o = headDat_q;
    assign rsp_err_o = headErr_q;
    assign state_o   = state_q;

    // Occupancy FSM: enqueue fills head first, then tail; dequeue shifts tail into head.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= EMPTY;
            headDat_q <= '0;
            headErr_q <= 1'b0;
            tailDat_q <= '0;
            tailErr_q <= 1'b0;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (enq_vld_i) begin
                        headDat_q <= enq_dat_i;
                        headErr_q <= enq_err_i;
                        state_q   <= ONE;
                    end
                end
                ONE: begin
                    if (enq_vld_i && deq) begin
                        headDat_q <= enq_dat_i;
                        headErr_q <= enq_err_i;
                    end else if (enq_vld_i) begin
                        tailDat_q <= enq_dat_i;
                        tailErr_q <= enq_err_i;
                        state_q   <= TWO;
                    end else if (deq) begin
                        state_q   <= EMPTY;
                    end
                end
                TWO: begin
                    if (deq) begin
                        headDat_q <= tailDat_q;
                        headErr_q <= tailErr_q;
                        if (enq_vld_i) begin
                            tailDat_q <= enq_dat_i;
                            tailErr_q <= enq_err_i;
                        end else begin
                            state_q <= ONE;
                        end
                    end
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

endmodule

// File: rtl/stack_engine.sv
// stack_engine: LIFO storage serving push/pop commands over stack_engine_if.
// Pops go through a 2-credit response buffer so one pop per cycle is
// sustained without any combinational path from the response ready.
// Optional feature macro: STACK_ENGINE_UNDERFLOW_ERR_EN (pop on empty returns
// an error response instead of being refused).
module stack_engine
    import stack_pkg::*;
#(
    parameter  int N     = 16,
    parameter  int W     = 32,
    localparam int LVL_W = $clog2(N + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    stack_engine_if.slave    bus,
    output logic             o_empty,
    output logic             o_full,
    output logic [LVL_W-1:0] o_level
);

    localparam int               AW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(N);
    localparam logic [1:0]       CREDITS  = 2'(STACK_RSP_DEPTH);

    logic [W-1:0]     memArray [N];
    logic [LVL_W-1:0] lvl_q, lvl_d;
    logic [1:0]       cnt_q, cnt_d;

    logic             isPop;
    logic             cmdRdy;
    logic             pushAcc;
    logic             popAcc;
    logic             popRead;
    logic             enqErr;
    logic [W-1:0]     enqDat;
    logic             rspDeq;
    logic [AW-1:0]    wrIdx;
    logic [AW-1:0]    rdIdx;
    logic             bufErr;
    logic [W-1:0]     bufDat;
    stack_rsp_st_t    bufState;

    assign isPop   = (stack_op_t'(bus.i_cmd_op) == POP);
    assign o_empty = (lvl_q == '0);
    assign o_full  = (lvl_q == FULL_LVL);
    assign o_level = lvl_q;

    // Command ready depends only on the op and registered state; clear blocks everything.
    always_comb begin
        cmdRdy = 1'b0;
        if (i_clr) begin
            cmdRdy = 1'b0;
        end else if (isPop) begin
`ifdef STACK_ENGINE_UNDERFLOW_ERR_EN
            cmdRdy = (cnt_q < CREDITS);
`else
            cmdRdy = (cnt_q < CREDITS) && !o_empty;
`endif
        end else begin
            cmdRdy = !o_full;
        end
    end

    assign bus.o_cmd_rdy = cmdRdy;
    assign pushAcc       = bus.i_cmd_vld && cmdRdy && !isPop;
    assign popAcc        = bus.i_cmd_vld && cmdRdy && isPop;
    assign popRead       = popAcc && !o_empty;
    assign wrIdx         = AW'(lvl_q);
    assign rdIdx         = AW'(lvl_q - LVL_W'(1));
    assign enqDat        = popRead ? memArray[rdIdx] : '0;
    assign rspDeq        = bus.o_rsp_vld && bus.i_rsp_rdy;

`ifdef STACK_ENGINE_UNDERFLOW_ERR_EN
    assign enqErr = popAcc && o_empty;
`else
    assign enqErr = 1'b0;
`endif

    // Next occupancy: clear wins, then a push grows and a real pop shrinks the stack.
    always_comb begin
        lvl_d = lvl_q;
        if (i_clr) begin
            lvl_d = '0;
        end else if (pushAcc) begin
            lvl_d = lvl_q + LVL_W'(1);
        end else if (popRead) begin
            lvl_d = lvl_q - LVL_W'(1);
        end
    end

    // Credit count: every accepted pop takes a slot, every response handshake returns one.
    always_comb begin
        cnt_d = cnt_q;
        case ({popAcc, rspDeq})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer and credit registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            lvl_q <= '0;
            cnt_q <= '0;
        end else begin
            lvl_q <= lvl_d;
            cnt_q <= cnt_d;
        end
    end

    // Storage array write; contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (pushAcc) begin
            memArray[wrIdx] <= bus.i_cmd_dat;
        end
    end

    stack_rsp_buf #(
        .W(W)
    ) u_rsp_buf (
        .clk       (clk),
        .rst       (rst),
        .enq_vld_i (popAcc),
        .enq_err_i (enqErr),
        .enq_dat_i (enqDat),
        .deq_rdy_i (bus.i_rsp_rdy),
        .rsp_err_o (bufErr),
        .rsp_dat_o (bufDat),
        .state_o   (bufState)
    );

    assign bus.o_rsp_vld = (bufState != EMPTY);
    assign bus.o_rsp_dat = bufDat;
    assign bus.o_rsp_err = bufErr;

endmodule

// File: tb/tb_stack_engine.sv
// tb_stack_engine: directed scoreboard bench for stack_engine (N=16, W=32).
// Pop-on-empty expectations follow STACK_ENGINE_UNDERFLOW_ERR_EN.
module tb_stack_engine;
    import stack_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       iClr;
    logic       oEmpty;
    logic       oFull;
    logic [4:0] oLevel;

    stack_engine_if #(.W(32)) bus ();

    stack_engine #(
        .N(16),
        .W(32)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .i_clr   (iClr),
        .bus     (bus),
        .o_empty (oEmpty),
        .o_full  (oFull),
        .o_level (oLevel)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [32:0] expQ[$];
    logic [31:0] modelStk[$];
    logic        holdValid = 1'b0;
    logic [32:0] holdRsp;

    task automatic checkOutput(input string name, input logic [32:0] actual, input logic [32:0] required);
        total++;
        if (actual !== required) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, actual, required);
        end
    endtask

    // Drive one command for one cycle; an accepted pop queues its expected response.
    task automatic applyStimulus(input logic vld, input logic op, input logic [31:0] dat,
                                 input logic clr, output logic accepted);
        bus.i_cmd_vld = vld;
        bus.i_cmd_op  = op;
        bus.i_cmd_dat = dat;
        iClr          = clr;
        @(negedge clk);
        accepted = vld & bus.o_cmd_rdy;
        if (accepted) begin
            if (op == POP) begin
                if (modelStk.size() > 0) expQ.push_back({1'b0, modelStk.pop_back()});
                else                     expQ.push_back({1'b1, 32'h0});
            end else begin
                modelStk.push_back(dat);
            end
        end
        if (clr) modelStk.delete();
        @(posedge clk);
        #1;
        bus.i_cmd_vld = 1'b0;
        iClr          = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Response monitor: compares every handshake against the scoreboard and checks hold stability.
    always @(negedge clk) begin
        if (rst) begin
            expQ.delete();
            holdValid = 1'b0;
        end else begin
            if (holdValid) begin
                checkOutput("rspHeldValid", {32'b0, bus.o_rsp_vld}, 33'd1);
                if (bus.o_rsp_vld) checkOutput("rspHeldData", {bus.o_rsp_err, bus.o_rsp_dat}, holdRsp);
            end
            if (bus.o_rsp_vld && bus.i_rsp_rdy) begin
                if (expQ.size() == 0) begin
                    total++;
                    bad++;
                    $display("[TB] FAIL rspUnexpected: got %0h, want no response", bus.o_rsp_dat);
                end else begin
                    checkOutput("rspData", {bus.o_rsp_err, bus.o_rsp_dat}, expQ.pop_front());
                end
                holdValid = 1'b0;
            end else if (bus.o_rsp_vld) begin
                holdValid = 1'b1;
                holdRsp   = {bus.o_rsp_err, bus.o_rsp_dat};
            end else begin
                holdValid = 1'b0;
            end
        end
    end

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, want finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence.
    initial begin
        logic acc;
        int   nAcc;

        rst           = 1'b1;
        iClr          = 1'b0;
        bus.i_cmd_vld = 1'b0;
        bus.i_cmd_op  = 1'b0;
        bus.i_cmd_dat = '0;
        bus.i_rsp_rdy = 1'b1;
        idle(3);
        rst = 1'b0;

        $display("[TB] reset values");
        checkOutput("rstRspVld", bus.o_rsp_vld, 0);
        checkOutput("rstRspDat", bus.o_rsp_dat, 0);
        checkOutput("rstRspErr", bus.o_rsp_err, 0);
        checkOutput("rstEmpty",  oEmpty, 1);
        checkOutput("rstFull",   oFull, 0);
        checkOutput("rstLevel",  oLevel, 0);

        $display("[TB] basic push/pop");
        applyStimulus(1'b1, PUSH, 32'hA, 1'b0, acc);
        applyStimulus(1'b1, PUSH, 32'hB, 1'b0, acc);
        applyStimulus(1'b1, PUSH, 32'hC, 1'b0, acc);
        checkOutput("levelAfter3Push", oLevel, 3);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, POP, 32'h0, 1'b0, acc);
            checkOutput("popAccept", acc, 1);
            checkOutput("rspLatency", bus.o_rsp_vld, 1);
            checkOutput("levelDuringPops", oLevel, 33'(2 - i));
        end
        checkOutput("emptyAfterPops", oEmpty, 1);
        idle(2);

        $display("[TB] fill to full");
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, PUSH, 32'h100 + 32'(i), 1'b0, acc);
        checkOutput("fullFlag", oFull, 1);
        checkOutput("fullLevel", oLevel, 16);
        applyStimulus(1'b1, PUSH, 32'hDEAD, 1'b0, acc);
        checkOutput("pushAtFullRefused", acc, 0);
        applyStimulus(1'b1, POP, 32'h0, 1'b0, acc);
        checkOutput("popFromFull", acc, 1);
        checkOutput("fullClearedAfterPop", oFull, 0);
        applyStimulus(1'b1, PUSH, 32'h1AA, 1'b0, acc);
        checkOutput("pushAfterPop", acc, 1);
        checkOutput("fullAgain", oFull, 1);

        $display("[TB] back-pressure");
        bus.i_rsp_rdy = 1'b0;
        nAcc = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, POP, 32'h0, 1'b0, acc);
            nAcc += int'(acc);
        end
        checkOutput("bpAccepted", 33'(nAcc), 2);
        checkOutput("bpLevel", oLevel, 14);
        bus.i_rsp_rdy = 1'b1;
        applyStimulus(1'b1, POP, 32'h0, 1'b0, acc);
        checkOutput("popNoCreditYet", acc, 0);
        nAcc = 0;
        for (int i = 0; i < 14; i++) begin
            applyStimulus(1'b1, POP, 32'h0, 1'b0, acc);
            nAcc += int'(acc);
        end
        checkOutput("sustainedPops", 33'(nAcc), 14);
        checkOutput("drainedLevel", oLevel, 0);
        idle(2);

        $display("[TB] pop on empty");
        applyStimulus(1'b1, POP, 32'h0, 1'b0, acc);
`ifdef STACK_ENGINE_UNDERFLOW_ERR_EN
        checkOutput("emptyPopAccepted", acc, 1);
`else
        checkOutput("emptyPopRefused", acc, 0);
        checkOutput("emptyPopNoRsp", bus.o_rsp_vld, 0);
`endif
        checkOutput("emptyPopLevel", oLevel, 0);
        idle(2);

        $display("[TB] clear with pending response");
        for (int i = 1; i <= 5; i++) applyStimulus(1'b1, PUSH, 32'h50 + 32'(i), 1'b0, acc);
        bus.i_rsp_rdy = 1'b0;
        applyStimulus(1'b1, POP, 32'h0, 1'b0, acc);
        checkOutput("clrPopAccept", acc, 1);
        applyStimulus(1'b1, PUSH, 32'h77, 1'b1, acc);
        checkOutput("clrNoAccept", acc, 0);
        checkOutput("clrLevel", oLevel, 0);
        checkOutput("clrEmpty", oEmpty, 1);
        checkOutput("clrRspPending", bus.o_rsp_vld, 1);
        bus.i_rsp_rdy = 1'b1;
        idle(2);
        applyStimulus(1'b1, PUSH, 32'h99, 1'b0, acc);
        applyStimulus(1'b1, POP, 32'h0, 1'b0, acc);
        idle(2);

        $display("[TB] reset with buffered responses");
        applyStimulus(1'b1, PUSH, 32'h61, 1'b0, acc);
        applyStimulus(1'b1, PUSH, 32'h62, 1'b0, acc);
        bus.i_rsp_rdy = 1'b0;
        applyStimulus(1'b1, POP, 32'h0, 1'b0, acc);
        applyStimulus(1'b1, POP, 32'h0, 1'b0, acc);
        checkOutput("preRstRspVld", bus.o_rsp_vld, 1);
        rst = 1'b1;
        modelStk.delete();
        idle(1);
        checkOutput("postRstRspVld", bus.o_rsp_vld, 0);
        checkOutput("postRstEmpty", oEmpty, 1);
        checkOutput("postRstLevel", oLevel, 0);
        rst = 1'b0;
        bus.i_rsp_rdy = 1'b1;
        idle(3);

        for (int i = 0; i < 20 && expQ.size() != 0; i++) idle(1);
        checkOutput("queueDrained", 33'(expQ.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
